// File: rtl/knn_sort_ctrl.sv
// knn_sort_ctrl
//   Sequences NUM_CH phase-1 k-sorters for one KNN query. It clears the sorters,
//   gates distance lanes into them until num_points distances are accepted, waits
//   one cycle for the last sorter writes to land, then drains K results per channel
//   as a valid/ready stream for the phase-2 merge / readback logic.
//
// Ports
//   clk, reset       clock; synchronous active-high reset (also clears the sorters)
//   start            begin a query (sampled only in IDLE)
//   num_points       total distances for the query, latched on start
//   busy             high in every state except IDLE
//   query_done       one-cycle pulse in the cycle after the query completes
//   in_valid         per-lane "distance present"
//   in_ready         per-lane accept (combinational)
//   sort_reset       shared sorter reset
//   sort_valid       per-sorter write strobe (equals in_ready)
//   sort_done        shared sorter done (high while draining)
//   sort_out_en      per-sorter read-pointer advance (combinational)
//   sort_name_in     sorter name outputs, channel 0 in the LSBs
//   sort_value_in    sorter value outputs, channel 0 in the LSBs
//   m_valid/m_ready  result stream handshake
//   m_name, m_value  result beat payload from the selected channel
//   m_chan, m_rank   source channel and rank (0 = nearest) of the beat
//   m_last           final beat of the query
//   dbgState         current FSM state (IDLE=0 CLEAR=1 STREAM=2 SETTLE=3 DRAIN=4)
//
// Stream handshake: a beat transfers on a cycle where m_valid && m_ready. While
// m_valid is high and m_ready is low every beat field is held stable and no sorter
// read pointer moves; m_valid never drops until the beat transfers (except on reset).
module knn_sort_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int K         = 4,
  parameter int VAL_WIDTH = 32,
  parameter int CNT_WIDTH = 32,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RKW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        num_points,
  output logic                        busy,
  output logic                        query_done,
  input  logic [NUM_CH-1:0]           in_valid,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        sort_reset,
  output logic [NUM_CH-1:0]           sort_valid,
  output logic                        sort_done,
  output logic [NUM_CH-1:0]           sort_out_en,
  input  logic [NUM_CH*32-1:0]        sort_name_in,
  input  logic [NUM_CH*VAL_WIDTH-1:0] sort_value_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [31:0]                 m_name,
  output logic [VAL_WIDTH-1:0]        m_value,
  output logic [CHW-1:0]              m_chan,
  output logic [RKW-1:0]              m_rank,
  output logic                        m_last,
  output logic [2:0]                  dbgState
);

  localparam int PCW = $clog2(NUM_CH + 1);
  localparam logic [CHW-1:0] CHAN_LAST = CHW'(NUM_CH - 1);
  localparam logic [RKW-1:0] RANK_LAST = RKW'(K - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    SETTLE = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t               state, stateNext;
  logic [CNT_WIDTH-1:0] remaining, remainingNext;
  logic [CHW-1:0]       chan, chanNext;
  logic [RKW-1:0]       rank, rankNext;
  logic                 queryDoneNext;
  logic [NUM_CH-1:0]    accept;
  logic [NUM_CH-1:0]    outEn;
  logic [PCW-1:0]       prefix;
  logic [PCW-1:0]       acceptCnt;

  // Lane acceptance: a valid lane is taken when the number of valid lanes at or
  // below it still fits in the remaining budget, so lower lanes win. Because the
  // prefix count only grows, the last accepted prefix is the accept count, and the
  // comparison is done on the prefix, so remaining can never underflow.
  always_comb begin
    accept    = '0;
    prefix    = '0;
    acceptCnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_valid[i]) begin
        prefix = prefix + PCW'(1);
        if (CNT_WIDTH'(prefix) <= remaining) begin
          accept[i] = 1'b1;
          acceptCnt = prefix;
        end
      end
    end
    if (state != STREAM) begin
      accept    = '0;
      acceptCnt = '0;
    end
  end

  // Next-state and drain sequencing.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    chanNext      = chan;
    rankNext      = rank;
    queryDoneNext = 1'b0;
    outEn         = '0;
    case (state)
      IDLE: begin
        if (start) begin
          remainingNext = num_points;
          stateNext     = CLEAR;
        end
      end
      CLEAR: begin
        if (remaining == '0) begin
          stateNext     = IDLE;
          queryDoneNext = 1'b1;
        end else begin
          stateNext = STREAM;
        end
      end
      STREAM: begin
        remainingNext = remaining - CNT_WIDTH'(acceptCnt);
        if (remaining == CNT_WIDTH'(acceptCnt)) begin
          stateNext = SETTLE;
        end
      end
      SETTLE: begin
        chanNext  = '0;
        rankNext  = '0;
        stateNext = DRAIN;
      end
      DRAIN: begin
        if (m_ready) begin
          if (rank != RANK_LAST) begin
            // Advance this sorter's read pointer so the next rank is presented
            // next cycle; the final rank of a channel needs no advance.
            outEn[chan] = 1'b1;
            rankNext    = rank + RKW'(1);
          end else begin
            rankNext = '0;
            if (chan == CHAN_LAST) begin
              chanNext      = '0;
              stateNext     = IDLE;
              queryDoneNext = 1'b1;
            end else begin
              chanNext = chan + CHW'(1);
            end
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      chan       <= '0;
      rank       <= '0;
      query_done <= 1'b0;
    end else begin
      state      <= stateNext;
      remaining  <= remainingNext;
      chan       <= chanNext;
      rank       <= rankNext;
      query_done <= queryDoneNext;
    end
  end

  // Result mux: present the selected channel's current sorter output.
  always_comb begin
    m_name  = '0;
    m_value = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan == CHW'(i)) begin
        m_name  = sort_name_in[i*32 +: 32];
        m_value = sort_value_in[i*VAL_WIDTH +: VAL_WIDTH];
      end
    end
  end

  assign busy        = (state != IDLE);
  assign in_ready    = accept;
  assign sort_valid  = accept;
  // Reset also clears the sorters, so an aborted query leaves no stale entries.
  assign sort_reset  = reset | (state == CLEAR);
  assign sort_done   = (state == DRAIN);
  assign sort_out_en = outEn;
  assign m_valid     = (state == DRAIN);
  assign m_chan      = chan;
  assign m_rank      = rank;
  assign m_last      = (state == DRAIN) && (chan == CHAN_LAST) && (rank == RANK_LAST);
  assign dbgState    = state;

endmodule
